// File: rtl/dcpu16_mbus_pkg.sv
// Shared types and constants for the dcpu16 memory-bus arbiter.
package dcpu16_mbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Read data returned to the requester when the watchdog aborts a cycle.
  localparam logic [63:0] ABORT_DATA = '1;

  localparam int TMO_DEFAULT = 255;

endpackage

// File: rtl/dcpu16_rrarb.sv
// Combinational round-robin picker: the search starts one past the last winner.
module dcpu16_rrarb #(
  parameter int CH = 2,
  parameter int LW = $clog2(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [LW-1:0] last,
  output logic [CH-1:0] gnt,
  output logic          any
);

  logic [LW-1:0] sel;

  // Walk from the farthest position back to the nearest, so the nearest requester wins.
  always_comb begin
    gnt = '0;
    sel = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      sel = LW'((int'(last) + 1 + k) % CH);
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dcpu16_mbus_arb.sv
// Round-robin arbiter merging CH requesters onto one shared memory port.
// Optional bus watchdog enabled by defining DCPU16_MBUS_TIMEOUT_EN.
module dcpu16_mbus_arb
  import dcpu16_mbus_pkg::*;
#(
  parameter int CH  = 2,
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*AW-1:0] c_adr,
  input  logic [CH-1:0]    c_stb,
  input  logic [CH-1:0]    c_wre,
  input  logic [CH*DW-1:0] c_dto,
  output logic [DW-1:0]    c_dti,
  output logic [CH-1:0]    c_ack,
  output logic             c_err,
  output logic [AW-1:0]    m_adr,
  output logic             m_stb,
  output logic             m_wre,
  output logic [DW-1:0]    m_dto,
  input  logic [DW-1:0]    m_dti,
  input  logic             m_ack,
  output logic             ena
);

  localparam int LW = $clog2(CH);

  if (CH < 2 || CH > 8) begin : g_bad_ch
    $error("dcpu16_mbus_arb: CH must be in 2..8");
  end
  if (TMO < 1 || TMO > 65535) begin : g_bad_tmo
    $error("dcpu16_mbus_arb: TMO must be in 1..65535");
  end

  state_t        state, state_nx;
  logic [CH-1:0] gnt_w;
  logic          any_w;
  logic [LW-1:0] win_idx, gnt_idx, last_q;
  logic [CH-1:0] gnt_q;
  logic [AW-1:0] sel_adr;
  logic          sel_wre;
  logic [DW-1:0] sel_dto;
  logic          load, finish, abort, expire;

  dcpu16_rrarb #(.CH(CH), .LW(LW)) u_rrarb (
    .req  (c_stb),
    .last (last_q),
    .gnt  (gnt_w),
    .any  (any_w)
  );

  always_comb begin
    win_idx = '0;
    sel_adr = '0;
    sel_wre = 1'b0;
    sel_dto = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt_w[i]) begin
        win_idx = LW'(i);
        sel_adr = c_adr[i*AW +: AW];
        sel_wre = c_wre[i];
        sel_dto = c_dto[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_w) state_nx = BUS;
      BUS:     if (m_ack || expire) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // An ack arriving in the expiry cycle takes precedence over the abort.
  always_comb begin
    load   = (state == IDLE) && any_w;
    finish = (state == BUS) && (m_ack || expire);
    abort  = finish && !m_ack;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_adr   <= '0;
      m_stb   <= 1'b0;
      m_wre   <= 1'b0;
      m_dto   <= '0;
      c_dti   <= '0;
      c_ack   <= '0;
      gnt_q   <= '0;
      gnt_idx <= '0;
      last_q  <= LW'(CH - 1);
    end else begin
      c_ack <= '0;
      if (load) begin
        m_adr   <= sel_adr;
        m_wre   <= sel_wre;
        m_dto   <= sel_dto;
        m_stb   <= 1'b1;
        gnt_q   <= gnt_w;
        gnt_idx <= win_idx;
      end
      if (finish) begin
        m_stb  <= 1'b0;
        c_dti  <= abort ? ABORT_DATA[DW-1:0] : m_dti;
        c_ack  <= gnt_q;
        last_q <= gnt_idx;
      end
    end
  end

`ifdef DCPU16_MBUS_TIMEOUT_EN
  localparam int TW = 16;
  logic [TW-1:0] cnt;
  logic          err_q;

  // cnt holds the number of BUS cycles elapsed, including the current one.
  assign expire = (state == BUS) && (cnt == TW'(TMO));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (load)              cnt <= TW'(1);
      else if (state == BUS) cnt <= cnt + TW'(1);
    end
  end

  assign c_err = err_q;
`else
  assign expire = 1'b0;
  assign c_err  = 1'b0;
`endif

  assign ena = &(~c_stb | c_ack);

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// Directed bench for dcpu16_mbus_arb with a transaction-level monitor model.
module tb_dcpu16_mbus_arb;

  localparam int TMO_TB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] c_adr = '0;
  logic [1:0]  c_stb = '0;
  logic [1:0]  c_wre = '0;
  logic [31:0] c_dto = '0;
  logic [15:0] c_dti;
  logic [1:0]  c_ack;
  logic        c_err;
  logic [15:0] m_adr;
  logic        m_stb, m_wre;
  logic [15:0] m_dto, m_dti;
  logic        m_ack;
  logic        ena;
  logic        auto_ack = 1'b0, man_ack = 1'b0;
  logic [15:0] man_dti = '0;

  assign m_ack = auto_ack ? m_stb : man_ack;
  assign m_dti = auto_ack ? (m_adr ^ 16'h5A5A) : man_dti;

  logic [63:0] c_adr4 = 64'h0030_0020_0010_0000;
  logic [3:0]  c_stb4 = '0;
  logic [3:0]  c_wre4 = '0;
  logic [63:0] c_dto4 = '0;
  logic [15:0] c_dti4, m_adr4, m_dto4, m_dti4;
  logic [3:0]  c_ack4;
  logic        c_err4, m_stb4, m_wre4, m_ack4, ena4;

  assign m_ack4 = m_stb4;
  assign m_dti4 = m_adr4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcpu16_mbus_arb #(.CH(2), .AW(16), .DW(16), .TMO(TMO_TB)) dut (
    .clk(clk), .rst(rst_n), .c_adr(c_adr), .c_stb(c_stb), .c_wre(c_wre), .c_dto(c_dto),
    .c_dti(c_dti), .c_ack(c_ack), .c_err(c_err), .m_adr(m_adr), .m_stb(m_stb),
    .m_wre(m_wre), .m_dto(m_dto), .m_dti(m_dti), .m_ack(m_ack), .ena(ena)
  );

  dcpu16_mbus_arb #(.CH(4), .AW(16), .DW(16)) dut4 (
    .clk(clk), .rst(rst_n), .c_adr(c_adr4), .c_stb(c_stb4), .c_wre(c_wre4), .c_dto(c_dto4),
    .c_dti(c_dti4), .c_ack(c_ack4), .c_err(c_err4), .m_adr(m_adr4), .m_stb(m_stb4),
    .m_wre(m_wre4), .m_dto(m_dto4), .m_dti(m_dti4), .m_ack(m_ack4), .ena(ena4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr2(input logic [1:0] req, input int last);
    for (int k = 1; k <= 2; k++) begin
      if (req[(last + k) % 2]) return (last + k) % 2;
    end
    return 0;
  endfunction

  // Monitor model: a transaction is seen as ready -> busy (n cycles) -> acked -> ready.
  typedef enum {PH_READY, PH_BUSY, PH_ACKED} phase_t;
  phase_t      ph = PH_READY;
  int          cur = 0, last_w = 1, nbus = 0;
  logic        err_exp = 1'b0;
  logic [15:0] dti_exp = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_m_stb", m_stb, 0);
      chk("rst_c_ack", c_ack, 0);
      chk("rst_c_err", c_err, 0);
      chk("rst_m_adr", m_adr, 0);
      chk("rst_c_dti", c_dti, 0);
      ph = PH_READY;
      last_w = 1;
    end else begin
      chk("mon_ena", ena, &(~c_stb | c_ack));
      case (ph)
        PH_READY: begin
          chk("mon_idle_m_stb", m_stb, 0);
          chk("mon_idle_c_ack", c_ack, 0);
          if (|c_stb) begin
            cur  = rr2(c_stb, last_w);
            nbus = 0;
            ph   = PH_BUSY;
          end
        end
        PH_BUSY: begin
          chk("mon_bus_m_stb", m_stb, 1);
          chk("mon_bus_c_ack", c_ack, 0);
          chk("mon_bus_m_adr", m_adr, c_adr[cur*16 +: 16]);
          chk("mon_bus_m_wre", m_wre, c_wre[cur]);
          chk("mon_bus_m_dto", m_dto, c_dto[cur*16 +: 16]);
          nbus++;
          if (m_ack) begin
            err_exp = 1'b0;
            dti_exp = m_dti;
            ph = PH_ACKED;
          end
`ifdef DCPU16_MBUS_TIMEOUT_EN
          else if (nbus == TMO_TB) begin
            err_exp = 1'b1;
            dti_exp = 16'hFFFF;
            ph = PH_ACKED;
          end
`endif
        end
        default: begin
          chk("mon_resp_c_ack", c_ack, 64'd1 << cur);
          chk("mon_resp_m_stb", m_stb, 0);
          chk("mon_resp_c_dti", c_dti, dti_exp);
          chk("mon_resp_c_err", c_err, err_exp);
          last_w = cur;
          ph = PH_READY;
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nacks;
    logic [1:0]  alog[4];
    bit          ok;
    int          ord[8];
    int          lastpos[4];
    int          maxgap;
    int          exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Test 1: both channels strobing through reset; service alternates from channel 0.
    c_adr    = {16'h0200, 16'h0100};
    c_stb    = 2'b11;
    auto_ack = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    nacks = 0;
    for (int n = 0; n < 40 && nacks < 4; n++) begin
      @(posedge clk); #1;
      if (c_ack != 0) begin
        alog[nacks] = c_ack;
        nacks++;
        if (nacks == 3) c_stb[0] = 1'b0;
        if (nacks == 4) c_stb = 2'b00;
      end
    end
    chk("t1_ack_count", nacks, 4);
    chk("t1_ack0", alog[0], 2'b01);
    chk("t1_ack1", alog[1], 2'b10);
    chk("t1_ack2", alog[2], 2'b01);
    auto_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Test 2: zero-wait read on channel 1.
    c_adr[31:16] = 16'h1234;
    c_stb = 2'b10;
    #1 chk("t2_ena_req", ena, 0);
    @(posedge clk); #1;
    chk("t2_m_stb", m_stb, 1);
    chk("t2_m_adr", m_adr, 16'h1234);
    chk("t2_ena_bus", ena, 0);
    man_dti = 16'hBEEF;
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    chk("t2_c_ack", c_ack, 2'b10);
    chk("t2_c_dti", c_dti, 16'hBEEF);
    chk("t2_c_err", c_err, 0);
    chk("t2_ena_resp", ena, 1);
    c_stb = 2'b00;
    @(posedge clk); #1;
    chk("t2_ack_once", c_ack, 0);
    @(posedge clk); #1;
    chk("t2_no_reissue", m_stb, 0);

    // Test 3: channel 0 write with three wait states.
    c_adr[15:0] = 16'h8000;
    c_dto[15:0] = 16'h00A5;
    c_wre = 2'b01;
    c_stb = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t3_m_stb", m_stb, 1);
      chk("t3_m_wre", m_wre, 1);
      chk("t3_m_dto", m_dto, 16'h00A5);
      chk("t3_m_adr", m_adr, 16'h8000);
      chk("t3_no_ack", c_ack, 0);
      if (i == 3) man_ack = 1'b1;
    end
    @(posedge clk); #1;
    man_ack = 1'b0;
    chk("t3_c_ack", c_ack, 2'b01);
    c_stb = 2'b00;
    c_wre = 2'b00;
    @(posedge clk); #1;
    chk("t3_ack_pulse", c_ack, 0);
    @(posedge clk); #1;

    // Test 4: reset in the middle of a bus cycle, then a stray ack.
    c_adr[15:0] = 16'h4444;
    c_stb = 2'b01;
    @(posedge clk); #1;
    chk("t4_m_stb_before", m_stb, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_m_stb_async", m_stb, 0);
    chk("t4_c_ack_async", c_ack, 0);
    c_stb = 2'b00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t4_late_ack_c_ack", c_ack, 0);
      chk("t4_late_ack_m_stb", m_stb, 0);
    end
    man_ack = 1'b0;
    c_adr = {16'h0BBB, 16'h0AAA};
    c_stb = 2'b11;
    @(posedge clk); #1;
    chk("t4_prio_after_rst", m_adr, 16'h0AAA);
    auto_ack = 1'b1;
    @(posedge clk); #1;
    chk("t4_first_ack", c_ack, 2'b01);
    c_stb = 2'b10;
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(posedge clk); #1;
      if (c_ack == 2'b10) ok = 1'b1;
    end
    chk("t4_second_ack_seen", ok, 1);
    c_stb = 2'b00;
    auto_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef DCPU16_MBUS_TIMEOUT_EN
    // Test 5: watchdog abort, then an ack landing in the expiry cycle.
    c_adr[15:0] = 16'h1000;
    c_stb = 2'b01;
    for (int i = 0; i < TMO_TB; i++) begin
      @(posedge clk); #1;
      chk("t5_m_stb_wait", m_stb, 1);
    end
    @(posedge clk); #1;
    chk("t5_m_stb_drop", m_stb, 0);
    chk("t5_c_ack", c_ack, 2'b01);
    chk("t5_c_err", c_err, 1);
    chk("t5_c_dti", c_dti, 16'hFFFF);
    c_stb = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    c_stb = 2'b01;
    for (int i = 0; i < TMO_TB; i++) begin
      @(posedge clk); #1;
      chk("t5b_m_stb_wait", m_stb, 1);
      if (i == TMO_TB - 1) begin
        man_dti = 16'h1357;
        man_ack = 1'b1;
      end
    end
    @(posedge clk); #1;
    man_ack = 1'b0;
    chk("t5b_c_ack", c_ack, 2'b01);
    chk("t5b_c_err", c_err, 0);
    chk("t5b_c_dti", c_dti, 16'h1357);
    c_stb = 2'b00;
    repeat (2) @(posedge clk);
    #1;
`endif

    // Test 6: four channels requesting continuously.
    c_stb4 = 4'hF;
    nacks = 0;
    for (int n = 0; n < 60 && nacks < 8; n++) begin
      @(posedge clk); #1;
      if (c_ack4 != 0) begin
        ord[nacks] = -1;
        for (int c = 0; c < 4; c++) if (c_ack4 == (4'b1 << c)) ord[nacks] = c;
        nacks++;
      end
    end
    chk("t6_ack_count", nacks, 8);
    maxgap = 0;
    for (int c = 0; c < 4; c++) lastpos[c] = -1;
    for (int i = 0; i < nacks; i++) begin
      chk("t6_order", ord[i], exp_ord[i]);
      if (ord[i] >= 0) begin
        if (lastpos[ord[i]] >= 0 && i - lastpos[ord[i]] - 1 > maxgap)
          maxgap = i - lastpos[ord[i]] - 1;
        lastpos[ord[i]] = i;
      end
    end
    chk("t6_max_wait", (maxgap <= 3), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcpu16_mbus_arb.md
# dcpu16_mbus_arb

Parametrised memory-bus arbiter that merges CH independent Simplified-Wishbone requesters onto one shared memory port. Typical requesters are instruction fetch, operand read, result write-back and DMA. Each transaction on the shared port completes before the next one issues. Grants are round-robin. The block adds write data, a registered response path, a global pipe-stall `ena` for the core, and an optional bus-timeout watchdog.

## Interface
Parameters:
- `CH`, default 2: number of requester channels, range 2–8.
- `AW`, default 16: address width.
- `DW`, default 16: data width.
- `TMO`, default 255: watchdog limit in cycles. Used only with the timeout feature.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `c_adr` in CH*AW: per-channel address. Channel i occupies bits [i*AW +: AW].
- `c_stb` in CH: per-channel request strobe.
- `c_wre` in CH: per-channel write enable.
- `c_dto` in CH*DW: per-channel write data.
- `c_dti` out DW: read data, shared by all channels. Valid with `c_ack`.
- `c_ack` out CH: one-hot, one-cycle completion pulse.
- `c_err` out 1: completion was a timeout abort. Valid with `c_ack`.
- `m_adr` out AW: shared-port address.
- `m_stb` out 1: shared-port strobe.
- `m_wre` out 1: shared-port write enable.
- `m_dto` out DW: shared-port write data.
- `m_dti` in DW: shared-port read data.
- `m_ack` in 1: shared-port acknowledge.
- `ena` out 1: pipe enable, equal to &(~c_stb | c_ack). Combinational.

## Operation
- The FSM has three states: IDLE, BUS and RESP.
- IDLE:
  - If any `c_stb` is high, pick a winner by round-robin. Search starts at `last+1` (mod CH).
  - Latch the winner's `adr`/`wre`/`dto` into `m_*`, set `m_stb`=1, record the winner in `gnt`, go to BUS.
  - If no `c_stb` is high, stay in IDLE with `m_stb`=0.
- BUS:
  - Hold all `m_*` outputs stable.
  - On `m_ack`: `m_stb`←0, `c_dti`←`m_dti` (captured on writes as well), `c_ack[gnt]`←1, `c_err`←0, `last`←`gnt`, go to RESP.
- RESP:
  - `c_ack` and `c_err` are high for this cycle only, then go to IDLE.
  - The arbiter does not sample `c_stb` in RESP. This lets a requester drop its strobe, or present a new request, on the edge that ends RESP. A held request therefore never re-issues twice.
- Requester rules:
  - `adr`/`wre`/`dto` stay stable while `c_stb` is high and no ack has arrived.
  - Dropping `c_stb` before its ack arrives is illegal. Behaviour in that case is undefined.
- Round-robin pointer:
  - `last` resets to CH-1, so channel 0 has priority first after reset.
  - A channel that requests continuously waits at most CH-1 transactions.
- Reset:
  - Asserting `rst` low at any time, including mid-BUS, clears everything immediately without waiting for a clock edge.
  - All outputs go to 0, the FSM goes to IDLE, and `last` goes to CH-1.
  - Any in-flight shared-port cycle is abandoned. A later `m_ack` for it is ignored because the FSM is in IDLE.
- `m_ack` is ignored in IDLE and RESP.

## Timing
- Best-case latency is 3 cycles from request to ack:
  - `c_stb` is sampled at edge 0.
  - `m_stb` is high after edge 0.
  - With a zero-wait slave, `m_ack` is seen at edge 1.
  - `c_ack` is high after edge 1 for one cycle (RESP).
  - The next `m_stb` can rise after edge 3.
- Shared-port throughput is one transfer per 3 cycles with zero wait states.
- Every wait-state cycle of `m_ack` adds exactly one cycle.
- `ena` is combinationally low while any requester is strobing and has not yet been acked. It is high during that requester's RESP cycle.

## Configuration
- `DCPU16_MBUS_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to BUS and increments on each BUS cycle.
  - When the counter equals `TMO` with `m_ack` low, the block aborts. Abort means: `m_stb`←0, `c_dti`←all ones, `c_ack[gnt]`←1, `c_err`←1, `last`←`gnt`, go to RESP.
  - If `m_ack` and expiry happen in the same cycle, the ack wins and `c_err`=0.
- `DCPU16_MBUS_TIMEOUT_EN` undefined:
  - There is no counter, and BUS waits indefinitely.
  - `c_err` is tied to 0.

## Structure
- Package `dcpu16_mbus_pkg` holds:
  - State encodings: IDLE=2'd0, BUS=2'd1, RESP=2'd2.
  - The all-ones abort data constant.
  - The default `TMO` constant.
- Sub-module `dcpu16_rrarb` is the purely combinational round-robin picker.
  - Inputs: `req`[CH], `last`.
  - Outputs: one-hot `gnt`[CH] and `any`.
- Registers and the FSM stay in `dcpu16_mbus_arb`.

## Test plan
- Reset with CH=2, `c_stb`=2'b11 held: after release, channel 0 is served first (`m_adr`=`c_adr[0]`), then channel 1, then channel 0. `c_ack` pulses 01, 10, 01.
- Zero-wait read: channel 1 requests adr 16'h1234 and the slave returns 16'hBEEF with ack on the first BUS cycle. Required: `c_ack`=2'b10 exactly 2 edges after the request edge, `c_dti`=16'hBEEF, `c_err`=0, `ena` low for 2 cycles and then high.
- Write with 3 wait states: channel 0 writes 16'h00A5 to 16'h8000. Required: `m_wre`=1 and `m_dto`=16'h00A5 stable for 4 BUS cycles, then `c_ack`=2'b01 for one cycle.
- Reset mid-BUS: pull `rst` low between edges. Required: `m_stb`=0 and `c_ack`=0 immediately. After release, a late `m_ack` produces no `c_ack`.
- With the macro defined and TMO=4, the slave never acks. Required: `m_stb` drops after 4 BUS cycles, `c_ack` pulses, `c_err`=1, `c_dti`=16'hFFFF. A second run with `m_ack` arriving on cycle 4 gives `c_err`=0.
- CH=4, all channels request continuously: the grant order is 0,1,2,3,0,… and no channel waits for more than 3 other transfers.
